hf4137_4_2_encoder: RTL and testbench

Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 active-low decoder. It watches four active-low request lines, latches each falling edge as a pending event, and presents one binary index at a time on a valid/ready output port. Priority among pending events is fixed or round-robin, and lost events are flagged. It sits between pin-level request inputs and an internal consumer.

---
 rtl/hf4137_4_2_encoder.sv | 149 ++++++++++++++
 tb/tb_hf4137_4_2_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hf4137_4_2_encoder.sv
// hf4137_4_2_encoder: sequential 4-to-2 encoder for active-low request
// lines, with a valid/ready output, fixed or round-robin priority and overflow.
module hf4137_4_2_encoder #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_n,
  input  logic       en_n,
  input  logic       out_ready,
  input  logic       ovf_clr,
  output logic       out_valid,
  output logic [1:0] out_code,
  output logic       any_pend,
  output logic       ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [3:0] req_s1_q, req_s1_d;
  logic [3:0] req_s2_q, req_s2_d;
  logic [3:0] req_prev_q, req_prev_d;
  logic       en_s1_q, en_s1_d;
  logic       en_s2_q, en_s2_d;
  logic [3:0] pend_q, pend_d;
  state_t     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [1:0] last_q, last_d;
  logic       any_pend_q, any_pend_d;
  logic       ovf_q, ovf_d;

  logic [3:0] edge_v;
  logic [3:0] acc_v;
  logic       accept;

  // Highest set index wins.
  function automatic logic [1:0] pick_hi(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) r = 2'(k);
    end
    return r;
  endfunction

  // First set index searching upward from s, wrapping 3 -> 0.
  function automatic logic [1:0] pick_rr(
    input logic [3:0] v,
    input logic [1:0] s
  );
    logic [1:0] r;
    logic [1:0] i;
    r = s;
    for (int k = 3; k >= 0; k--) begin
      i = s + 2'(k);
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [1:0] pick(
    input logic [3:0] v,
    input logic [1:0] lst
  );
    if (ROUND_ROBIN) return pick_rr(v, lst + 2'd1);
    return pick_hi(v);
  endfunction

  // Synchronisers, edge detect, pending set/clear, overflow and offer FSM.
  always_comb begin
    req_s1_d   = req_n;
    req_s2_d   = req_s1_q;
    req_prev_d = req_s2_q;
    en_s1_d    = en_n;
    en_s2_d    = en_s1_q;

    edge_v = ~req_s2_q & req_prev_q & {4{~en_s2_q}};
    accept = (state_q == OFFER) && out_ready;
    acc_v  = accept ? (4'b0001 << code_q) : 4'b0000;
    pend_d = (pend_q & ~acc_v) | edge_v;

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (|(edge_v & pend_q & ~acc_v)) ovf_d = 1'b1;

    last_d  = accept ? code_q : last_q;
    state_d = state_q;
    code_d  = code_q;

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          code_d  = pick(pend_q, last_q);
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          if (|pend_d) begin
            code_d = pick(pend_d, code_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    any_pend_d = (|pend_d) | (state_d == OFFER);
  end

  // State registers; reset drops the offer and every pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1_q   <= 4'hF;
      req_s2_q   <= 4'hF;
      req_prev_q <= 4'hF;
      en_s1_q    <= 1'b1;
      en_s2_q    <= 1'b1;
      pend_q     <= 4'h0;
      state_q    <= IDLE;
      code_q     <= 2'd0;
      last_q     <= 2'd3;
      any_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      req_s1_q   <= req_s1_d;
      req_s2_q   <= req_s2_d;
      req_prev_q <= req_prev_d;
      en_s1_q    <= en_s1_d;
      en_s2_q    <= en_s2_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      code_q     <= code_d;
      last_q     <= last_d;
      any_pend_q <= any_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == OFFER);
  assign out_code  = code_q;
  assign any_pend  = any_pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hf4137_4_2_encoder.sv
// tb_hf4137_4_2_encoder: runs fixed-priority and round-robin encoders
// side by side on shared stimulus, scoreboarding every transfer.
module tb_hf4137_4_2_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] req_n;
  logic       en_n;
  logic       out_ready;
  logic       ovf_clr;

  logic       v_fp, v_rr;
  logic [1:0] c_fp, c_rr;
  logic       ap_fp, ap_rr;
  logic       ovf_fp, ovf_rr;

  int n_vec = 0;
  int n_err = 0;
  int q_fp[$];
  int q_rr[$];

  hf4137_4_2_encoder #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_n(req_n), .en_n(en_n),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(v_fp), .out_code(c_fp),
    .any_pend(ap_fp), .ovf(ovf_fp)
  );

  hf4137_4_2_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req_n(req_n), .en_n(en_n),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(v_rr), .out_code(c_rr),
    .any_pend(ap_rr), .ovf(ovf_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_fp.size() != 0 || q_rr.size() != 0) && n < 60) begin
      cyc(1);
      n++;
    end
    chk("drain_fp", q_fp.size(), 0);
    chk("drain_rr", q_rr.size(), 0);
  endtask

  // Transfers complete on the next rising edge; sample midway.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (v_fp) begin
        if (q_fp.size() == 0) chk("fp_extra", q_fp.size(), 1);
        else chk("fp_code", int'(c_fp), q_fp.pop_front());
      end
      if (v_rr) begin
        if (q_rr.size() == 0) chk("rr_extra", q_rr.size(), 1);
        else chk("rr_code", int'(c_rr), q_rr.pop_front());
      end
    end
  end

  initial begin
    int exp_fp[3];
    int exp_rr[3];
    exp_fp = '{3, 1, 0};
    exp_rr = '{3, 0, 1};

    rst = 1'b1;
    req_n = 4'hF;
    en_n = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    cyc(3);
    chk("rst_valid", int'(v_fp), 0);
    chk("rst_code", int'(c_fp), 0);
    chk("rst_pend", int'(ap_fp), 0);
    chk("rst_ovf", int'(ovf_rr), 0);
    rst = 1'b0;
    cyc(3);

    // single request on line 2, latency 3 from the sampling edge
    out_ready = 1'b1;
    req_n = 4'b1011;
    q_fp.push_back(2);
    q_rr.push_back(2);
    cyc(3);
    chk("single_early", int'(v_fp), 0);
    cyc(1);
    chk("single_valid", int'(v_fp), 1);
    chk("single_code", int'(c_fp), 2);
    chk("single_code_rr", int'(c_rr), 2);
    cyc(1);
    chk("single_once", int'(v_fp), 0);
    chk("single_pend", int'(ap_fp), 0);
    chk("single_ovf", int'(ovf_fp), 0);
    req_n = 4'hF;
    drain();
    cyc(4);

    // lines 0,1,3 together while stalled
    out_ready = 1'b0;
    req_n = 4'b0100;
    foreach (exp_fp[i]) q_fp.push_back(exp_fp[i]);
    foreach (exp_rr[i]) q_rr.push_back(exp_rr[i]);
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(v_fp), 1);
      chk("stall_code", int'(c_fp), 3);
      chk("stall_code_rr", int'(c_rr), 3);
      cyc(1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", int'(v_fp), 1);
      chk("b2b_code", int'(c_fp), exp_fp[i]);
      chk("b2b_code_rr", int'(c_rr), exp_rr[i]);
      cyc(1);
    end
    chk("b2b_done", int'(v_fp), 0);
    req_n = 4'hF;
    drain();
    cyc(4);

    // round-robin from reset: all four, then lines 1 and 3
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    req_n = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      q_fp.push_back(3 - i);
      q_rr.push_back(i);
    end
    drain();
    req_n = 4'hF;
    cyc(4);
    req_n = 4'b0101;
    q_fp.push_back(3);
    q_fp.push_back(1);
    q_rr.push_back(1);
    q_rr.push_back(3);
    drain();
    req_n = 4'hF;
    cyc(4);

    // overflow: re-fall line 2 while its event is still on offer
    out_ready = 1'b0;
    req_n = 4'b1011;
    q_fp.push_back(2);
    q_rr.push_back(2);
    cyc(6);
    chk("ovf_offer", int'(c_rr), 2);
    chk("ovf_before", int'(ovf_fp), 0);
    req_n = 4'hF;
    cyc(3);
    req_n = 4'b1011;
    cyc(4);
    chk("ovf_set_fp", int'(ovf_fp), 1);
    chk("ovf_set_rr", int'(ovf_rr), 1);
    req_n = 4'hF;
    out_ready = 1'b1;
    drain();
    cyc(2);
    chk("ovf_single", int'(v_fp), 0);
    chk("ovf_sticky", int'(ovf_fp), 1);
    ovf_clr = 1'b1;
    chk("ovf_clr_pre", int'(ovf_rr), 1);
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr_fp", int'(ovf_fp), 0);
    chk("ovf_clr_rr", int'(ovf_rr), 0);
    cyc(3);

    // new edge on line 1 lands on the accept of index 1
    out_ready = 1'b0;
    req_n = 4'b1101;
    q_fp.push_back(1);
    q_fp.push_back(1);
    q_rr.push_back(1);
    q_rr.push_back(1);
    cyc(5);
    chk("coin_offer", int'(c_fp), 1);
    req_n = 4'hF;
    cyc(3);
    req_n = 4'b1101;
    cyc(2);
    out_ready = 1'b1;
    cyc(1);
    chk("coin_again", int'(v_fp), 1);
    chk("coin_code", int'(c_fp), 1);
    drain();
    chk("coin_ovf_fp", int'(ovf_fp), 0);
    chk("coin_ovf_rr", int'(ovf_rr), 0);
    req_n = 4'hF;
    cyc(4);

    // enable blocks new edges
    en_n = 1'b1;
    cyc(3);
    req_n = 4'b0000;
    cyc(8);
    chk("en_valid", int'(v_fp), 0);
    chk("en_pend", int'(ap_rr), 0);
    req_n = 4'hF;
    cyc(4);
    en_n = 1'b0;
    cyc(4);

    // reset while offering
    out_ready = 1'b0;
    req_n = 4'b1110;
    cyc(6);
    chk("rst_mid_offer", int'(v_fp), 1);
    chk("rst_mid_pend", int'(ap_fp), 1);
    rst = 1'b1;
    req_n = 4'hF;
    cyc(1);
    chk("rst_drop_v", int'(v_fp), 0);
    chk("rst_drop_p", int'(ap_fp), 0);
    chk("rst_drop_rr", int'(v_rr), 0);
    cyc(1);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(10);
    chk("rst_after_v", int'(v_rr), 0);
    chk("rst_after_p", int'(ap_rr), 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
